// File: rtl/budget_arbiter.sv
// ---------------------------------------------------------------------------
// budget_arbiter
//   Non-preemptive static-priority arbiter with per-queue grant budgets that
//   are replenished every `period` cycles. A queue is eligible while it holds
//   a packet and still has budget left. The highest priority wins, and ties
//   go to the lowest index. Once a grant is presented it is held until the
//   downstream accepts it.
//
// Ports
//   clock       : single clock; all state changes on the rising edge
//   reset       : asynchronous, active-low
//   priorities  : static priority per queue (0 = lowest)
//   budgets     : grants allowed per queue per replenishment period
//   period      : replenishment period in cycles (0 behaves as 1)
//   free        : bit j set = queue j holds at least one packet
//   grant_ready : downstream accepts the presented grant this cycle
//   grant_valid : a grant is presented
//   grant_id    : granted queue index, stable while grant_valid is high
//   pop         : one-hot dequeue strobe, high in the acceptance cycle
//   exhausted   : bit j set = queue j has no budget left this period
// ---------------------------------------------------------------------------
module budget_arbiter #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int PRIORITY_SIZE    = 4,
    parameter int BUDGET_SIZE      = 8,
    parameter int PERIOD_SIZE      = 16
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic [NUMBER_OF_QUEUES-1:0][PRIORITY_SIZE-1:0]   priorities,
    input  logic [NUMBER_OF_QUEUES-1:0][BUDGET_SIZE-1:0]     budgets,
    input  logic [PERIOD_SIZE-1:0]                           period,
    input  logic [NUMBER_OF_QUEUES-1:0]                      free,
    input  logic                                             grant_ready,
    output logic                                             grant_valid,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]              grant_id,
    output logic [NUMBER_OF_QUEUES-1:0]                      pop,
    output logic [NUMBER_OF_QUEUES-1:0]                      exhausted
);

    localparam int ID_WIDTH = $clog2(NUMBER_OF_QUEUES);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [PERIOD_SIZE-1:0] PERIOD_ZERO = {PERIOD_SIZE{1'b0}};
    localparam logic [PERIOD_SIZE-1:0] PERIOD_ONE  = {{(PERIOD_SIZE-1){1'b0}}, 1'b1};
    localparam logic [BUDGET_SIZE-1:0] BUDGET_ZERO = {BUDGET_SIZE{1'b0}};
    localparam logic [BUDGET_SIZE-1:0] BUDGET_ONE  = {{(BUDGET_SIZE-1){1'b0}}, 1'b1};

    logic [0:0]                                    state_r;
    logic [0:0]                                    state_next_s;
    logic [PERIOD_SIZE-1:0]                        count_r;
    logic [PERIOD_SIZE-1:0]                        count_next_s;
    logic [PERIOD_SIZE-1:0]                        last_count_s;
    logic [NUMBER_OF_QUEUES-1:0][BUDGET_SIZE-1:0]  remaining_r;
    logic [NUMBER_OF_QUEUES-1:0][BUDGET_SIZE-1:0]  remaining_next_s;
    logic [NUMBER_OF_QUEUES-1:0]                   eligible_s;
    logic                                          any_eligible_s;
    logic [ID_WIDTH-1:0]                           sel_id_s;
    logic [PRIORITY_SIZE-1:0]                      best_prio_s;
    logic [ID_WIDTH-1:0]                           grant_id_r;
    logic                                          accept_s;
    logic [BUDGET_SIZE-1:0]                        base_s;

    // Decrement that sticks at zero instead of wrapping.
    function automatic logic [BUDGET_SIZE-1:0] sat_dec(input logic [BUDGET_SIZE-1:0] value);
        if (value == BUDGET_ZERO) begin
            sat_dec = BUDGET_ZERO;
        end else begin
            sat_dec = value - BUDGET_ONE;
        end
    endfunction

    assign accept_s    = (state_r == GRANT) && grant_ready;
    assign grant_valid = (state_r == GRANT);
    assign grant_id    = grant_id_r;

    // Period counter: a period of 0 is treated as 1, so the counter sits at 0
    // and reloads every cycle. Using >= also recovers cleanly if period shrinks.
    always_comb begin
        last_count_s = PERIOD_ZERO;
        count_next_s = PERIOD_ZERO;
        if (period == PERIOD_ZERO) begin
            last_count_s = PERIOD_ZERO;
        end else begin
            last_count_s = period - PERIOD_ONE;
        end
        if (count_r >= last_count_s) begin
            count_next_s = PERIOD_ZERO;
        end else begin
            count_next_s = count_r + PERIOD_ONE;
        end
    end

    // Eligibility and priority selection; strict '>' keeps the lowest index on ties.
    always_comb begin
        eligible_s     = {NUMBER_OF_QUEUES{1'b0}};
        any_eligible_s = 1'b0;
        sel_id_s       = {ID_WIDTH{1'b0}};
        best_prio_s    = {PRIORITY_SIZE{1'b0}};
        for (int j = 0; j < NUMBER_OF_QUEUES; j++) begin
            eligible_s[j] = free[j] && (remaining_r[j] != BUDGET_ZERO);
            if (eligible_s[j] && (!any_eligible_s || (priorities[j] > best_prio_s))) begin
                any_eligible_s = 1'b1;
                sel_id_s       = ID_WIDTH'(j);
                best_prio_s    = priorities[j];
            end else begin
                any_eligible_s = any_eligible_s;
                sel_id_s       = sel_id_s;
                best_prio_s    = best_prio_s;
            end
        end
    end

    // Budget update: reload at counter 0 first, then apply an accepted grant,
    // so a coincident reload and acceptance yields budgets[id]-1.
    always_comb begin
        remaining_next_s = remaining_r;
        base_s           = BUDGET_ZERO;
        for (int j = 0; j < NUMBER_OF_QUEUES; j++) begin
            if (count_r == PERIOD_ZERO) begin
                base_s = budgets[j];
            end else begin
                base_s = remaining_r[j];
            end
            if (accept_s && (grant_id_r == ID_WIDTH'(j))) begin
                remaining_next_s[j] = sat_dec(base_s);
            end else begin
                remaining_next_s[j] = base_s;
            end
        end
    end

    // Two-state grant FSM; GRANT only leaves on acceptance (non-preemptive).
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (any_eligible_s) begin
                    state_next_s = GRANT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = GRANT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // One-hot dequeue strobe in the acceptance cycle.
    always_comb begin
        pop = {NUMBER_OF_QUEUES{1'b0}};
        if (accept_s) begin
            pop[grant_id_r] = 1'b1;
        end else begin
            pop = {NUMBER_OF_QUEUES{1'b0}};
        end
    end

    // Exhausted flags follow the remaining budgets directly.
    always_comb begin
        exhausted = {NUMBER_OF_QUEUES{1'b0}};
        for (int j = 0; j < NUMBER_OF_QUEUES; j++) begin
            exhausted[j] = (remaining_r[j] == BUDGET_ZERO);
        end
    end

    // State, counter, budgets and latched grant ID.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            count_r     <= PERIOD_ZERO;
            remaining_r <= {(NUMBER_OF_QUEUES*BUDGET_SIZE){1'b0}};
            grant_id_r  <= {ID_WIDTH{1'b0}};
        end else begin
            state_r     <= state_next_s;
            count_r     <= count_next_s;
            remaining_r <= remaining_next_s;
            if ((state_r == IDLE) && any_eligible_s) begin
                grant_id_r <= sel_id_s;
            end else begin
                grant_id_r <= grant_id_r;
            end
        end
    end

endmodule

// File: tb/tb_budget_arbiter.sv
// ---------------------------------------------------------------------------
// tb_budget_arbiter
//   Directed, self-checking bench for budget_arbiter (4 queues, 4-bit
//   priorities, 8-bit budgets, 16-bit period). Each scenario task drives its
//   own stimulus and compares against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_budget_arbiter;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [3:0][3:0]      priorities;
    logic [3:0][7:0]      budgets;
    logic [15:0]          period;
    logic [3:0]           free;
    logic                 grant_ready;
    logic                 grant_valid;
    logic [1:0]           grant_id;
    logic [3:0]           pop;
    logic [3:0]           exhausted;

    int checks_total  = 0;
    int checks_passed = 0;

    budget_arbiter #(
        .NUMBER_OF_QUEUES (4),
        .PRIORITY_SIZE    (4),
        .BUDGET_SIZE      (8),
        .PERIOD_SIZE      (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .priorities  (priorities),
        .budgets     (budgets),
        .period      (period),
        .free        (free),
        .grant_ready (grant_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .pop         (pop),
        .exhausted   (exhausted)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_reset();
        reset = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        priorities  = {4'd3, 4'd2, 4'd1, 4'd0};
        budgets     = {8'd4, 8'd4, 8'd4, 8'd4};
        period      = 16'd10;
        free        = 4'b1111;
        grant_ready = 1'b1;
        tick();
        tick();
        checks_total++;
        if (grant_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", grant_valid);
        else checks_passed++;
        checks_total++;
        if (grant_id !== 2'd0) $display("FAIL reset_id: got %0d expected 0", grant_id);
        else checks_passed++;
        checks_total++;
        if (pop !== 4'b0000) $display("FAIL reset_pop: got %b expected 0000", pop);
        else checks_passed++;
        checks_total++;
        if (exhausted !== 4'b1111) $display("FAIL reset_exhausted: got %b expected 1111", exhausted);
        else checks_passed++;
        checks_total++;
        if (dut.count_r !== 16'd0) $display("FAIL reset_counter: got %0d expected 0", dut.count_r);
        else checks_passed++;
    endtask

    task automatic test_priority();
        logic [1:0] exp_ids [13];
        logic [3:0] exp_pop;
        logic [3:0] exp_exh;
        exp_ids = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        start_reset();
        priorities[0] = 4'd1;
        priorities[1] = 4'd5;
        priorities[2] = 4'd5;
        priorities[3] = 4'd2;
        budgets     = {8'd4, 8'd4, 8'd4, 8'd4};
        period      = 16'd100;
        free        = 4'b1111;
        grant_ready = 1'b1;
        reset       = 1'b1;
        tick();
        checks_total++;
        if (grant_valid !== 1'b0) $display("FAIL prio_no_early_grant: got %0b expected 0", grant_valid);
        else checks_passed++;
        tick();
        for (int k = 0; k < 13; k++) begin
            exp_pop = 4'b0001 << exp_ids[k];
            checks_total++;
            if (grant_valid !== 1'b1 || grant_id !== exp_ids[k] || pop !== exp_pop)
                $display("FAIL prio_grant_%0d: got valid=%0b id=%0d pop=%b expected valid=1 id=%0d pop=%b",
                         k, grant_valid, grant_id, pop, exp_ids[k], exp_pop);
            else checks_passed++;
            tick();
            exp_exh = 4'b0000;
            if (k >= 3)  exp_exh[1] = 1'b1;
            if (k >= 7)  exp_exh[2] = 1'b1;
            if (k >= 11) exp_exh[3] = 1'b1;
            checks_total++;
            if (grant_valid !== 1'b0 || exhausted !== exp_exh)
                $display("FAIL prio_idle_%0d: got valid=%0b exhausted=%b expected valid=0 exhausted=%b",
                         k, grant_valid, exhausted, exp_exh);
            else checks_passed++;
            tick();
        end
    endtask

    task automatic test_zero_budget();
        logic seen_valid;
        start_reset();
        priorities  = {4'd0, 4'd0, 4'd0, 4'd15};
        budgets     = {8'd3, 8'd3, 8'd3, 8'd0};
        period      = 16'd10;
        free        = 4'b0001;
        grant_ready = 1'b1;
        reset       = 1'b1;
        seen_valid  = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (grant_valid !== 1'b0 || pop !== 4'b0000) seen_valid = 1'b1;
        end
        checks_total++;
        if (seen_valid !== 1'b0) $display("FAIL zero_budget_no_grant: got a grant expected none");
        else checks_passed++;
        checks_total++;
        if (exhausted !== 4'b0001) $display("FAIL zero_budget_exhausted: got %b expected 0001", exhausted);
        else checks_passed++;
    endtask

    task automatic test_nonpreempt();
        logic held_ok;
        start_reset();
        priorities  = {4'd0, 4'd3, 4'd0, 4'd9};
        budgets     = {8'd5, 8'd5, 8'd5, 8'd5};
        period      = 16'd100;
        free        = 4'b0100;
        grant_ready = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        checks_total++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd2)
            $display("FAIL nonpre_first: got valid=%0b id=%0d expected valid=1 id=2", grant_valid, grant_id);
        else checks_passed++;
        held_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) free = 4'b0001;
            tick();
            if (grant_valid !== 1'b1 || grant_id !== 2'd2 || pop !== 4'b0000) held_ok = 1'b0;
        end
        checks_total++;
        if (held_ok !== 1'b1) $display("FAIL nonpre_hold: got valid=%0b id=%0d pop=%b expected valid=1 id=2 pop=0000", grant_valid, grant_id, pop);
        else checks_passed++;
        grant_ready = 1'b1;
        #1;
        checks_total++;
        if (pop !== 4'b0100) $display("FAIL nonpre_accept_pop: got %b expected 0100", pop);
        else checks_passed++;
        tick();
        checks_total++;
        if (grant_valid !== 1'b0) $display("FAIL nonpre_idle: got %0b expected 0", grant_valid);
        else checks_passed++;
        tick();
        checks_total++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0 || pop !== 4'b0001)
            $display("FAIL nonpre_next: got valid=%0b id=%0d pop=%b expected valid=1 id=0 pop=0001", grant_valid, grant_id, pop);
        else checks_passed++;
    endtask

    task automatic test_period_wrap();
        int pops;
        start_reset();
        priorities  = {4'd0, 4'd0, 4'd0, 4'd0};
        budgets     = {8'd1, 8'd1, 8'd1, 8'd1};
        period      = 16'd8;
        free        = 4'b0100;
        grant_ready = 1'b1;
        reset       = 1'b1;
        for (int w = 0; w < 3; w++) begin
            pops = 0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (pop !== 4'b0000) pops++;
                if (w == 0 && c == 6) begin
                    checks_total++;
                    if (dut.count_r !== 16'd7) $display("FAIL wrap_count_top: got %0d expected 7", dut.count_r);
                    else checks_passed++;
                end
                if (w == 0 && c == 7) begin
                    checks_total++;
                    if (dut.count_r !== 16'd0) $display("FAIL wrap_count_zero: got %0d expected 0", dut.count_r);
                    else checks_passed++;
                end
            end
            checks_total++;
            if (pops != 1) $display("FAIL wrap_pops_window_%0d: got %0d expected 1", w, pops);
            else checks_passed++;
        end
    endtask

    task automatic test_reload_collision();
        int  n;
        logic quiet;
        start_reset();
        priorities  = {4'd0, 4'd0, 4'd0, 4'd0};
        budgets     = {8'd3, 8'd3, 8'd3, 8'd3};
        period      = 16'd8;
        free        = 4'b0010;
        grant_ready = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        n = 0;
        while (dut.count_r !== 16'd0 && n < 20) begin
            tick();
            n++;
        end
        checks_total++;
        if (dut.count_r !== 16'd0 || grant_valid !== 1'b1 || grant_id !== 2'd1)
            $display("FAIL collide_setup: got count=%0d valid=%0b id=%0d expected count=0 valid=1 id=1", dut.count_r, grant_valid, grant_id);
        else checks_passed++;
        grant_ready = 1'b1;
        tick();
        checks_total++;
        if (dut.remaining_r[1] !== 8'd2 || exhausted[1] !== 1'b0)
            $display("FAIL collide_remaining: got %0d expected 2", dut.remaining_r[1]);
        else checks_passed++;
        tick();
        tick();
        tick();
        tick();
        checks_total++;
        if (exhausted[1] !== 1'b1 || grant_valid !== 1'b0)
            $display("FAIL collide_drain: got exhausted=%0b valid=%0b expected exhausted=1 valid=0", exhausted[1], grant_valid);
        else checks_passed++;
        // Budget of zero reloaded on the acceptance edge must stick at zero.
        grant_ready = 1'b0;
        n = 0;
        while (grant_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (dut.count_r !== 16'd0 && n < 20) begin
            tick();
            n++;
        end
        checks_total++;
        if (dut.count_r !== 16'd0 || grant_valid !== 1'b1)
            $display("FAIL sat_setup: got count=%0d valid=%0b expected count=0 valid=1", dut.count_r, grant_valid);
        else checks_passed++;
        budgets[1]  = 8'd0;
        grant_ready = 1'b1;
        tick();
        checks_total++;
        if (dut.remaining_r[1] !== 8'd0 || exhausted[1] !== 1'b1)
            $display("FAIL sat_zero: got remaining=%0d exhausted=%0b expected remaining=0 exhausted=1", dut.remaining_r[1], exhausted[1]);
        else checks_passed++;
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (grant_valid !== 1'b0) quiet = 1'b0;
        end
        checks_total++;
        if (quiet !== 1'b1) $display("FAIL sat_no_grant: got a grant expected none");
        else checks_passed++;
    endtask

    task automatic test_async_reset();
        start_reset();
        priorities  = {4'd0, 4'd0, 4'd0, 4'd0};
        budgets     = {8'd2, 8'd2, 8'd2, 8'd2};
        period      = 16'd100;
        free        = 4'b0001;
        grant_ready = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        checks_total++;
        if (grant_valid !== 1'b1) $display("FAIL areset_setup: got valid=%0b expected 1", grant_valid);
        else checks_passed++;
        #2;
        reset       = 1'b0;
        grant_ready = 1'b1;
        #1;
        checks_total++;
        if (grant_valid !== 1'b0 || pop !== 4'b0000)
            $display("FAIL areset_drop: got valid=%0b pop=%b expected valid=0 pop=0000", grant_valid, pop);
        else checks_passed++;
        checks_total++;
        if (exhausted !== 4'b1111 || grant_id !== 2'd0)
            $display("FAIL areset_state: got exhausted=%b id=%0d expected exhausted=1111 id=0", exhausted, grant_id);
        else checks_passed++;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        priorities  = '0;
        budgets     = '0;
        period      = 16'd0;
        free        = 4'b0000;
        grant_ready = 1'b0;
        test_reset();
        test_priority();
        test_zero_budget();
        test_nonpreempt();
        test_period_wrap();
        test_reload_collision();
        test_async_reset();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/budget_arbiter.md
BUDGET_ARBITER -- requirements
Module: budget_arbiter

Interface
REQ-001 Parameter NUMBER_OF_QUEUES, default 4: number of requesting queues; ID width is $clog2(NUMBER_OF_QUEUES).
REQ-002 Parameter PRIORITY_SIZE, default 4: width of each queue priority; 0 is the lowest priority.
REQ-003 Parameter BUDGET_SIZE, default 8: width of each per-period grant budget.
REQ-004 Parameter PERIOD_SIZE, default 16: width of the replenishment period.
REQ-005 Port clock, input, 1: single clock; all state changes on rising edge.
REQ-006 Port reset, input, 1: the reset is asynchronous and active-low.
REQ-007 Port priorities, input, [NUMBER_OF_QUEUES][PRIORITY_SIZE]: static priority per queue.
REQ-008 Port budgets, input, [NUMBER_OF_QUEUES][BUDGET_SIZE]: grants allowed per queue per period.
REQ-009 Port period, input, PERIOD_SIZE: replenishment period in cycles.
REQ-010 Port free, input, NUMBER_OF_QUEUES: bit j high = queue j holds at least one packet.
REQ-011 Port grant_ready, input, 1: downstream accepts the granted packet this cycle.
REQ-012 Port grant_valid, output, 1: a grant is presented.
REQ-013 Port grant_id, output, $clog2(NUMBER_OF_QUEUES): granted queue ID.
REQ-014 Port pop, output, NUMBER_OF_QUEUES: one-hot, one-cycle dequeue strobe to the granted queue.
REQ-015 Port exhausted, output, NUMBER_OF_QUEUES: bit j high = remaining budget of queue j is 0.

Function
REQ-016 Period counter SHALL count 0..period-1 and wrap to 0; period 0 SHALL behave as period 1.
REQ-017 When the counter equals 0, every remaining[j] SHALL be loaded from budgets[j].
REQ-018 Queue j SHALL be eligible when free[j]=1 and remaining[j]!=0.
REQ-019 Selection SHALL pick the eligible queue with the highest priority; ties SHALL go to the lowest index.
REQ-020 FSM SHALL have two states, IDLE and GRANT.
REQ-021 IDLE: if any queue is eligible, latch the selection into grant_id and go to GRANT next cycle; otherwise stay in IDLE.
REQ-022 GRANT: grant_valid=1, and grant_id SHALL stay stable until acceptance.
REQ-023 In GRANT with grant_ready=1: pop[grant_id] SHALL pulse in that same cycle, remaining[grant_id] SHALL decrement, and the FSM SHALL return to IDLE.
REQ-024 Arbitration SHALL be non-preemptive: no re-selection occurs while in GRANT, even if a higher-priority queue becomes eligible or free[grant_id] drops.
REQ-025 Latency: eligibility in IDLE at cycle t gives grant_valid at t+1; back-to-back grants to the same queue are at most one every 2 cycles.
REQ-026 Reload and decrement in the same cycle: the result SHALL be budgets[id]-1, saturating at 0.
REQ-027 A decrement SHALL never wrap below 0.
REQ-028 A queue with budgets[j]=0 SHALL never be granted.
REQ-029 exhausted SHALL be combinational from remaining (remaining[j]==0).

Reset
REQ-030 While reset=0, outputs SHALL be: state IDLE, counter 0, all remaining 0, grant_valid 0, grant_id 0, pop 0, exhausted all 1.
REQ-031 The first rising edge after reset release SHALL perform a reload (counter=0), so no grant is possible before cycle 2.
REQ-032 Reset asserted during GRANT SHALL drop grant_valid immediately without a pop.

Verification
REQ-033 Priorities {1,5,5,2}, free=1111, budgets all 4, period 100, grant_ready=1 -> grants 1,1,1,1,2,2,2,2,3... and exhausted[1]=1 after the 4th grant.
REQ-034 budgets={0,3,3,3}, priorities q0=15, free=0001 -> grant_valid stays 0 for a full period.
REQ-035 Queue 2 is granted with grant_ready=0 for 10 cycles, then q0 (higher priority) raises free -> grant_id stays 2; after acceptance, q0 is granted next.
REQ-036 period=8, budget 1, free=0100, ready=1 -> exactly one pop per 8-cycle window, counter wraps 7->0.
REQ-037 Acceptance coincides with counter=0, budget 3 -> remaining=2 on the next cycle.
REQ-038 Async reset asserted mid-GRANT -> grant_valid=0 and pop=0 before the next clock edge; all remaining=0.
